logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
// - Shares one 32-bit logic unit (XOR/AND/OR/NOR) between NUM_REQ requesters in the datapath.
// - Round-robin arbitration, valid/ready handshake per requester, registered result held until consumed.
// - Sits between the decode/issue stages and the shared logic unit; at most one operation in flight.
// PARAMETERS
// - WIDTH    32  operand/result width
// - NUM_REQ  2   number of requesters, legal 2..4
// - IDW      2   requester-id width, must satisfy 2**IDW >= NUM_REQ
// PORTS
// - clk        in   1              rising-edge clock
// - rst_n      in   1              asynchronous reset, active-low
// - req_valid  in   NUM_REQ        request pending, one bit per requester
// - req_ready  out  NUM_REQ        request accepted this cycle (one-hot or zero)
// - req_a      in   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
// - req_b      in   NUM_REQ*WIDTH  operand B, same packing
// - req_op     in   NUM_REQ*2      op per requester: 00 XOR, 01 AND, 10 OR, 11 NOR
// - rsp_valid  out  1              result available
// - rsp_id     out  IDW            index of requester owning rsp_data
// - rsp_data   out  WIDTH          result
// - rsp_ready  in   1              consumer takes result this cycle
// - busy       out  1              high in EXEC or RESP
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
// - FSM states IDLE, EXEC, RESP.
// - IDLE: if any req_valid, grant first requester at or after rr_ptr (wrapping mod NUM_REQ); assert that
//   req_ready bit combinationally in the same cycle; on clock edge latch a, b, op, id; go EXEC.
//   No req_valid: stay IDLE, req_ready=0.
// - Grant update: rr_ptr <= (granted_id + 1) mod NUM_REQ on the grant edge; last index wraps to 0.
// - EXEC: one cycle; rsp_data <= op(a,b) computed full WIDTH bitwise, no carries; rsp_id <= latched id;
//   rsp_valid <= 1; go RESP.
// - RESP: hold rsp_valid, rsp_id, rsp_data stable until rsp_ready=1; on that edge rsp_valid <= 0, go IDLE.
// - Latency: accept edge -> rsp_valid high 2 cycles later; minimum issue interval 3 cycles.
// - req_ready only asserted in IDLE; requests arriving in EXEC/RESP wait; a requester must hold req_valid
//   and operands stable until its req_ready is sampled high.
// - rsp_ready while rsp_valid=0: ignored. rsp_ready high on the first RESP cycle: completes that cycle.
// - Deasserting req_valid before grant: request withdrawn, no side effects.
// - Reset mid-operation: in-flight op discarded, no response produced, rr_ptr returns to 0.
// - rsp_data holds last value after consumption until next EXEC overwrites it.
// - busy = (state != IDLE).
// CONFIGURATION
// - LOGIC_ARB_STATS_EN defined: adds output grant_cnt [NUM_REQ*16], one 16-bit counter per requester,
//   incremented on each grant, wraps 16'hFFFF -> 0, cleared by rst_n.
// - LOGIC_ARB_STATS_EN undefined: port and counters absent; all other behaviour identical.
// TESTING
// - Reset: rst_n=0 with req_valid=2'b11 -> req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
// - Single XOR: req0 a=32'd1000000007, b=32'd143, op=00 -> rsp_valid 2 cycles after accept,
//   rsp_id=0, rsp_data=32'h3B9ACA88.
// - Round robin: req_valid=2'b11 held, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
// - Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready stays 0;
//   rsp_ready=1 -> IDLE next cycle, new grant accepted.
// - Ops: a=32'hF0F0_F0F0, b=32'hFF00_FF00 -> XOR 0FF00FF0, AND F000F000, OR FFF0FFF0, NOR 000F000F.
// - Async reset in EXEC: rst_n low mid-cycle -> rsp_valid=0 immediately, no response after release,
//   next grant goes to requester 0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit XOR/AND/OR/NOR unit between NUM_REQ requesters.
// Define LOGIC_ARB_STATS_EN to add o_grant_cnt, one 16-bit wrapping grant counter per requester.
module logic_unit_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    parameter int IDW     = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
    input  logic [NUM_REQ*2-1:0]     i_req_op,
    output logic                     o_rsp_valid,
    output logic [IDW-1:0]           o_rsp_id,
    output logic [WIDTH-1:0]         o_rsp_data,
    input  logic                     i_rsp_ready,
`ifdef LOGIC_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]    o_grant_cnt,
`endif
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic [IDW-1:0]     r_id;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_data;

    logic [2*NUM_REQ-1:0] w_valid_dbl;
    logic [NUM_REQ-1:0]   w_valid_rot;
    logic                 w_grant_valid;
    logic [IDW-1:0]       w_grant_id;
    logic [IDW-1:0]       w_next_ptr;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_sel_a;
    logic [WIDTH-1:0]     w_sel_b;
    logic [1:0]           w_sel_op;
    logic [WIDTH-1:0]     w_result;

    // Rotate the request vector so bit 0 is the requester at rr_ptr; lowest set bit wins.
    assign w_valid_dbl = {i_req_valid, i_req_valid};
    assign w_valid_rot = NUM_REQ'(w_valid_dbl >> r_rr_ptr);

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_valid_rot[k]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_next_ptr = IDW'((int'(w_grant_id) + 1) % NUM_REQ);
    assign w_accept   = i_rst_n && (r_state == IDLE) && w_grant_valid;

    always_comb begin
        w_sel_a     = '0;
        w_sel_b     = '0;
        w_sel_op    = '0;
        o_req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == IDW'(i)) begin
                w_sel_a        = i_req_a[i*WIDTH +: WIDTH];
                w_sel_b        = i_req_b[i*WIDTH +: WIDTH];
                w_sel_op       = i_req_op[i*2 +: 2];
                o_req_ready[i] = w_accept;
            end
        end
    end

    always_comb begin
        w_result = '0;
        case (r_op)
            2'b00:   w_result = r_a ^ r_b;
            2'b01:   w_result = r_a & r_b;
            2'b10:   w_result = r_a | r_b;
            default: w_result = ~(r_a | r_b);
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_op     <= w_sel_op;
                        r_id     <= w_grant_id;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_result;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    // Result and id stay frozen until the consumer takes them.
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = (r_state != IDLE);

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] r_grant_cnt [NUM_REQ];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant_id == IDW'(i)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign o_grant_cnt[g*16 +: 16] = r_grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin/logic-op reference model.
module tb_logic_unit_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 2;
    localparam int IDW     = 2;

    logic                     clk;
    logic                     rstN;
    logic [NUM_REQ-1:0]       reqValid;
    logic [NUM_REQ-1:0]       reqReady;
    logic [NUM_REQ*WIDTH-1:0] reqA;
    logic [NUM_REQ*WIDTH-1:0] reqB;
    logic [NUM_REQ*2-1:0]     reqOp;
    logic                     rspValid;
    logic [IDW-1:0]           rspId;
    logic [WIDTH-1:0]         rspData;
    logic                     rspReady;
    logic                     busy;
`ifdef LOGIC_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]    grantCnt;
`endif

    int checks = 0;
    int errors = 0;
    int rrPtr  = 0;

    logic_unit_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_req_valid (reqValid),
        .o_req_ready (reqReady),
        .i_req_a     (reqA),
        .i_req_b     (reqB),
        .i_req_op    (reqOp),
        .o_rsp_valid (rspValid),
        .o_rsp_id    (rspId),
        .o_rsp_data  (rspData),
        .i_rsp_ready (rspReady),
`ifdef LOGIC_ARB_STATS_EN
        .o_grant_cnt (grantCnt),
`endif
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [63:0] a,
                                 input logic [63:0] b, input logic [3:0] op);
        reqValid = valid;
        reqA     = a;
        reqB     = b;
        reqOp    = op;
    endtask

    function automatic logic [31:0] refOp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        case (op)
            2'd0:    return a ^ b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic int refGrant(input logic [1:0] mask, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx = (ptr + k) % NUM_REQ;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic resetDut();
        rstN     = 1'b0;
        reqValid = '0;
        rspReady = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rstN = 1'b1;
        tick();
        rrPtr = 0;
    endtask

    task automatic test_reset();
        rstN     = 1'b0;
        rspReady = 1'b0;
        applyStimulus(2'b11, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_F0F0_F0F0, 4'b0110);
        tick();
        tick();
        checks++;
        if (reqReady !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 00", reqReady); end
        checks++;
        if (rspValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rspValid); end
        checks++;
        if (rspData !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 00000000", rspData); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (rspId !== 2'd0) begin errors++; $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rspId); end
        reqValid = 2'b00;
        @(negedge clk);
        rstN = 1'b1;
        tick();
        rrPtr = 0;
    endtask

    task automatic test_single_xor();
        applyStimulus(2'b01, {32'd0, 32'd1000000007}, {32'd0, 32'd143}, 4'b0000);
        #1;
        checks++;
        if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL xor_req_ready: got %b expected 01", reqReady); end
        tick();
        reqValid = 2'b00;
        checks++;
        if (rspValid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL xor_exec_state: got valid=%b busy=%b expected valid=0 busy=1", rspValid, busy);
        end
        tick();
        checks++;
        if (rspValid !== 1'b1 || rspId !== 2'd0 || rspData !== 32'h3B9A_CA88) begin
            errors++; $display("[TB] FAIL xor_result: got valid=%b id=%0d data=%h expected valid=1 id=0 data=3b9aca88",
                               rspValid, rspId, rspData);
        end
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checks++;
        if (rspValid !== 1'b0 || busy !== 1'b0 || rspData !== 32'h3B9A_CA88) begin
            errors++; $display("[TB] FAIL xor_consumed: got valid=%b busy=%b data=%h expected valid=0 busy=0 data=3b9aca88",
                               rspValid, busy, rspData);
        end
        rrPtr = 1;
    endtask

    task automatic test_round_robin();
        logic [1:0] expReady;
        logic [31:0] expData;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0] op;
        int g;
        resetDut();
        a  = {32'h2222_2222, 32'h1111_1111};
        b  = {32'h0F0F_0000, 32'h00FF_FF00};
        op = 4'b10_01;
        applyStimulus(2'b11, a, b, op);
        rspReady = 1'b1;
        #1;
        for (int n = 0; n < 4; n++) begin
            g        = n % 2;
            expReady = 2'b01 << g;
            expData  = refOp(a[g*32 +: 32], b[g*32 +: 32], op[g*2 +: 2]);
            checks++;
            if (reqReady !== expReady) begin
                errors++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", n, reqReady, expReady);
            end
            tick();
            tick();
            checks++;
            if (rspValid !== 1'b1 || rspId !== 2'(g) || rspData !== expData) begin
                errors++; $display("[TB] FAIL rr_rsp_%0d: got valid=%b id=%0d data=%h expected valid=1 id=%0d data=%h",
                                   n, rspValid, rspId, rspData, g, expData);
            end
            tick();
        end
        reqValid = 2'b00;
        rspReady = 1'b0;
        rrPtr    = 0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0] op;
        logic [31:0] expData;
        logic [1:0] expReady;
        int g;
        int g2;
        a  = {32'hDEAD_BEEF, 32'hCAFE_F00D};
        b  = {32'h0000_FFFF, 32'hFFFF_0000};
        op = 4'b11_00;
        applyStimulus(2'b11, a, b, op);
        #1;
        g        = refGrant(2'b11, rrPtr);
        expReady = 2'b01 << g;
        expData  = refOp(a[g*32 +: 32], b[g*32 +: 32], op[g*2 +: 2]);
        checks++;
        if (reqReady !== expReady) begin errors++; $display("[TB] FAIL bp_grant: got %b expected %b", reqReady, expReady); end
        tick();
        tick();
        for (int h = 0; h < 5; h++) begin
            checks++;
            if (rspValid !== 1'b1 || rspData !== expData || rspId !== 2'(g) || reqReady !== 2'b00) begin
                errors++; $display("[TB] FAIL bp_hold_%0d: got valid=%b id=%0d data=%h ready=%b expected valid=1 id=%0d data=%h ready=00",
                                   h, rspValid, rspId, rspData, reqReady, g, expData);
            end
            tick();
        end
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        rrPtr    = (g + 1) % NUM_REQ;
        g2       = refGrant(2'b11, rrPtr);
        expReady = 2'b01 << g2;
        checks++;
        if (rspValid !== 1'b0 || busy !== 1'b0 || reqReady !== expReady) begin
            errors++; $display("[TB] FAIL bp_release: got valid=%b busy=%b ready=%b expected valid=0 busy=0 ready=%b",
                               rspValid, busy, reqReady, expReady);
        end
        expData = refOp(a[g2*32 +: 32], b[g2*32 +: 32], op[g2*2 +: 2]);
        tick();
        reqValid = 2'b00;
        tick();
        checks++;
        if (rspValid !== 1'b1 || rspId !== 2'(g2) || rspData !== expData) begin
            errors++; $display("[TB] FAIL bp_next_rsp: got valid=%b id=%0d data=%h expected valid=1 id=%0d data=%h",
                               rspValid, rspId, rspData, g2, expData);
        end
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        rrPtr    = (g2 + 1) % NUM_REQ;
    endtask

    task automatic test_ops();
        logic [31:0] expected [4];
        int g;
        expected[0] = 32'h0FF0_0FF0;
        expected[1] = 32'hF000_F000;
        expected[2] = 32'hFFF0_FFF0;
        expected[3] = 32'h000F_000F;
        for (int op = 0; op < 4; op++) begin
            applyStimulus(2'b11, {2{32'hF0F0_F0F0}}, {2{32'hFF00_FF00}}, {2{2'(op)}});
            #1;
            g = refGrant(2'b11, rrPtr);
            tick();
            reqValid = 2'b00;
            tick();
            checks++;
            if (rspValid !== 1'b1 || rspId !== 2'(g) || rspData !== expected[op]) begin
                errors++; $display("[TB] FAIL op_%0d: got valid=%b id=%0d data=%h expected valid=1 id=%0d data=%h",
                                   op, rspValid, rspId, rspData, g, expected[op]);
            end
            rspReady = 1'b1;
            tick();
            rspReady = 1'b0;
            rrPtr    = (g + 1) % NUM_REQ;
        end
    endtask

    task automatic test_random(input int iters);
        logic [1:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0] op;
        logic [1:0] expReady;
        logic [31:0] expData;
        int g;
        int holdCycles;
        for (int n = 0; n < iters; n++) begin
            mask = 2'($urandom_range(0, 3));
            a    = {$urandom(), $urandom()};
            b    = {$urandom(), $urandom()};
            op   = 4'($urandom());
            applyStimulus(mask, a, b, op);
            #1;
            g = refGrant(mask, rrPtr);
            if (g < 0) begin
                checks++;
                if (reqReady !== 2'b00 || busy !== 1'b0) begin
                    errors++; $display("[TB] FAIL rand_idle_%0d: got ready=%b busy=%b expected ready=00 busy=0", n, reqReady, busy);
                end
                tick();
                continue;
            end
            expReady = 2'b01 << g;
            checks++;
            if (reqReady !== expReady) begin
                errors++; $display("[TB] FAIL rand_grant_%0d: got %b expected %b", n, reqReady, expReady);
            end
            if ($urandom_range(0, 4) == 0) begin
                applyStimulus(2'b00, a, b, op);
                tick();
                checks++;
                if (busy !== 1'b0 || rspValid !== 1'b0) begin
                    errors++; $display("[TB] FAIL rand_withdraw_%0d: got busy=%b valid=%b expected busy=0 valid=0", n, busy, rspValid);
                end
                continue;
            end
            expData = refOp(a[g*32 +: 32], b[g*32 +: 32], op[g*2 +: 2]);
            tick();
            applyStimulus(2'($urandom_range(0, 3)), a, b, op);
            #1;
            checks++;
            if (busy !== 1'b1 || rspValid !== 1'b0 || reqReady !== 2'b00) begin
                errors++; $display("[TB] FAIL rand_exec_%0d: got busy=%b valid=%b ready=%b expected busy=1 valid=0 ready=00",
                                   n, busy, rspValid, reqReady);
            end
            tick();
            checks++;
            if (rspValid !== 1'b1 || rspId !== 2'(g) || rspData !== expData) begin
                errors++; $display("[TB] FAIL rand_rsp_%0d: got valid=%b id=%0d data=%h expected valid=1 id=%0d data=%h",
                                   n, rspValid, rspId, rspData, g, expData);
            end
            holdCycles = $urandom_range(0, 3);
            for (int h = 0; h < holdCycles; h++) begin
                tick();
                checks++;
                if (rspValid !== 1'b1 || rspData !== expData || reqReady !== 2'b00) begin
                    errors++; $display("[TB] FAIL rand_hold_%0d: got valid=%b data=%h ready=%b expected valid=1 data=%h ready=00",
                                       n, rspValid, rspData, reqReady, expData);
                end
            end
            rspReady = 1'b1;
            tick();
            rspReady = 1'b0;
            reqValid = 2'b00;
            checks++;
            if (rspValid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("[TB] FAIL rand_done_%0d: got valid=%b busy=%b expected valid=0 busy=0", n, rspValid, busy);
            end
            rrPtr = (g + 1) % NUM_REQ;
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] a;
        logic [63:0] b;
        a = {32'hAAAA_5555, 32'h1357_9BDF};
        b = {32'h0000_0000, 32'hFFFF_FFFF};
        resetDut();
        applyStimulus(2'b01, a, b, 4'b0000);
        rspReady = 1'b1;
        tick();
        reqValid = 2'b00;
        tick();
        tick();
        rspReady = 1'b0;
        applyStimulus(2'b11, a, b, 4'b0000);
        #1;
        checks++;
        if (reqReady !== 2'b10) begin errors++; $display("[TB] FAIL ar_pre_grant: got %b expected 10", reqReady); end
        tick();
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (rspValid !== 1'b0 || busy !== 1'b0 || reqReady !== 2'b00) begin
            errors++; $display("[TB] FAIL ar_immediate: got valid=%b busy=%b ready=%b expected valid=0 busy=0 ready=00",
                               rspValid, busy, reqReady);
        end
        reqValid = 2'b00;
        @(negedge clk);
        rstN  = 1'b1;
        rrPtr = 0;
        for (int h = 0; h < 3; h++) begin
            tick();
            checks++;
            if (rspValid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("[TB] FAIL ar_no_rsp_%0d: got valid=%b busy=%b expected valid=0 busy=0", h, rspValid, busy);
            end
        end
        applyStimulus(2'b11, a, b, 4'b0000);
        #1;
        checks++;
        if (reqReady !== 2'b01) begin errors++; $display("[TB] FAIL ar_post_grant: got %b expected 01", reqReady); end
        tick();
        reqValid = 2'b00;
        tick();
        checks++;
        if (rspValid !== 1'b1 || rspId !== 2'd0 || rspData !== refOp(a[31:0], b[31:0], 2'b00)) begin
            errors++; $display("[TB] FAIL ar_post_rsp: got valid=%b id=%0d data=%h expected valid=1 id=0 data=%h",
                               rspValid, rspId, rspData, refOp(a[31:0], b[31:0], 2'b00));
        end
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
    endtask

    initial begin
        rstN     = 1'b0;
        reqValid = '0;
        reqA     = '0;
        reqB     = '0;
        reqOp    = '0;
        rspReady = 1'b0;
        test_reset();
        test_single_xor();
        test_round_robin();
        test_backpressure();
        test_ops();
        test_random(40);
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
